// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon32/64 decryption core.
package simon_pkg;

  localparam int WORD_W     = 16;
  localparam int KEY_WORDS  = 4;
  localparam int ROUNDS     = 32;
  localparam int KEYX_STEPS = 28;
  localparam int SR_W       = 96;

  // z0 sequence, bit i holds z0[i]; the sequence has period 31
  localparam logic [61:0] Z0 = {31'b0110011100001101010010001011111,
                                31'b0110011100001101010010001011111};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEYX = 2'd1,
    ST_DEC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [KEY_WORDS-1:0][WORD_W-1:0] key_win_t;

  function automatic word_t rol(input word_t a, input int n);
    return word_t'((a << n) | (a >> (WORD_W - n)));
  endfunction

  function automatic word_t ror(input word_t a, input int n);
    return word_t'((a >> n) | (a << (WORD_W - n)));
  endfunction

  // Simon round function f(a) = (ROL1 a & ROL8 a) ^ ROL2 a
  function automatic word_t f_rnd(input word_t a);
    return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
  endfunction

endpackage

// File: rtl/simon_key_step.sv
// One key-schedule step over a 4-word window, forward (expand) or backward (rewind).
module simon_key_step
  import simon_pkg::*;
(
  input  key_win_t k_i,
  input  logic     z_i,
  input  logic     bwd_i,
  output word_t    k_o
);

  word_t a, b, c, t0, t1;

  // Forward: window k[i..i+3] -> k[i+4]. Backward: window k[j-3..j] -> k[j-4].
  // Both reduce to ~c ^ t ^ z ^ 3 with the operands picked by direction.
  always_comb begin
    a  = bwd_i ? k_i[2] : k_i[3];
    b  = bwd_i ? k_i[0] : k_i[1];
    c  = bwd_i ? k_i[3] : k_i[0];
    t0 = ror(a, 3) ^ b;
    t1 = t0 ^ ror(t0, 1);
    k_o = ~c ^ t1 ^ {{(WORD_W-1){1'b0}}, z_i} ^ word_t'(3);
  end

endmodule

// File: rtl/simon_dec.sv
// Simon32/64 decryptor: nibble-serial load/unload, key expansion, then 32 inverse rounds.
module simon_dec
  import simon_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_shift,
  input  logic       i_start,
  input  logic [3:0] i_data,
  output logic [3:0] o_data,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [4:0] KEYX_LAST  = 5'(KEYX_STEPS - 1);
  localparam logic [4:0] DEC_LAST   = 5'(ROUNDS - 1);
  localparam logic [4:0] Z_DEC_BASE = 5'(KEYX_STEPS - 1);

  state_e          state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  key_win_t        kw_q, kw_d;
  logic [4:0]      cnt_q, cnt_d;

  logic       dec_mode;
  logic [4:0] z_idx;
  logic       z_bit;
  word_t      k_new;
  word_t      x_q, y_q, x_nx, y_nx;

  assign dec_mode = (state_q == ST_DEC);
  // Rewinding from k[j] needs z0[j-4]; with j = 31 - cnt that is 27 - cnt.
  assign z_idx    = dec_mode ? (Z_DEC_BASE - cnt_q) : cnt_q;
  assign z_bit    = Z0[z_idx];

  simon_key_step u_key_step (
    .k_i   (kw_q),
    .z_i   (z_bit),
    .bwd_i (dec_mode),
    .k_o   (k_new)
  );

  // Ciphertext lives in the low 32 bits of sr and is updated in place.
  assign x_q  = sr_q[31:16];
  assign y_q  = sr_q[15:0];
  assign x_nx = y_q;
  assign y_nx = x_q ^ f_rnd(y_q) ^ kw_q[KEY_WORDS-1];

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    kw_d    = kw_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_shift) begin
          sr_d = {sr_q[SR_W-5:0], i_data};
        end else if (i_start) begin
          state_d = ST_KEYX;
          kw_d    = sr_q[SR_W-1 -: KEY_WORDS*WORD_W];
          cnt_d   = '0;
        end
      end
      ST_KEYX: begin
        kw_d = {k_new, kw_q[KEY_WORDS-1:1]};
        if (cnt_q == KEYX_LAST) begin
          state_d = ST_DEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_DEC: begin
        // For the last four rounds the shifted-in word is never consumed.
        kw_d  = {kw_q[KEY_WORDS-2:0], k_new};
        cnt_d = cnt_q + 5'd1;
        sr_d  = {sr_q[SR_W-1:32], x_nx, y_nx};
        if (cnt_q == DEC_LAST) begin
          state_d = ST_DONE;
          sr_d    = {x_nx, y_nx, 64'b0};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      kw_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      kw_q    <= kw_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_data = sr_q[SR_W-1 -: 4];
  assign o_busy = (state_q == ST_KEYX) || (state_q == ST_DEC);
  assign o_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_simon_dec.sv
// Scoreboard bench for simon_dec against a word-level Simon32/64 model.
module tb_simon_dec;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_shift;
  logic       i_start;
  logic [3:0] i_data;
  logic [3:0] o_data;
  logic       o_busy;
  logic       o_done;

  simon_dec dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_shift (i_shift),
    .i_start (i_start),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef logic [31:0][15:0] ks_t;
  typedef struct packed {
    logic [31:0] pt;
    logic        rd;
  } exp_t;

  localparam logic [95:0] KNOWN    = 96'h1918_1110_0908_0100_c69b_e9bb;
  localparam logic [31:0] KNOWN_PT = 32'h6565_6877;

  string z0s = "11111010001001010110000111001101111101000100101011000011100110";

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] rl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] ff(input logic [15:0] a);
    return (rl(a, 1) & rl(a, 8)) ^ rl(a, 2);
  endfunction

  function automatic ks_t expand(input logic [63:0] key);
    ks_t k;
    logic [15:0] t;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rl(k[i-1], 13) ^ k[i-3];
      t = t ^ rl(t, 15);
      k[i] = 16'hfffc ^ k[i-4] ^ t ^ ((z0s[i-4] == 8'h31) ? 16'd1 : 16'd0);
    end
    return k;
  endfunction

  function automatic logic [31:0] encrypt(input logic [63:0] key, input logic [31:0] pt);
    ks_t k = expand(key);
    logic [15:0] x = pt[31:16];
    logic [15:0] y = pt[15:0];
    logic [15:0] t;
    for (int r = 0; r < 32; r++) begin
      t = x;
      x = y ^ ff(x) ^ k[r];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [31:0] decrypt(input logic [63:0] key, input logic [31:0] ct);
    ks_t k = expand(key);
    logic [15:0] x = ct[31:16];
    logic [15:0] y = ct[15:0];
    logic [15:0] t;
    for (int r = 31; r >= 0; r--) begin
      t = y;
      y = x ^ ff(y) ^ k[r];
      x = t;
    end
    return {x, y};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [95:0] v);
    for (int i = 0; i < 24; i++) begin
      i_shift = 1'b1;
      i_data  = v[95 - 4*i -: 4];
      tick();
    end
    i_shift = 1'b0;
  endtask

  // Starts one operation; leaves the DUT in DONE unless a readout is requested.
  task automatic run_op(input logic [31:0] exp, input bit rd, input bit noise);
    exp_t e;
    int   c;
    int   busy_n;
    logic [31:0] r;
    e.pt = exp;
    e.rd = rd;
    exp_q.push_back(e);
    i_shift = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    c = 1;
    busy_n = o_busy ? 1 : 0;
    while (!o_done && c < 200) begin
      if (noise) begin
        r = $urandom;
        i_shift = r[0];
        i_start = r[1];
        i_data  = r[7:4];
      end
      tick();
      c++;
      if (o_busy) busy_n++;
    end
    i_shift = 1'b0;
    i_start = 1'b0;
    check("latency", 32'(c), 32'd61);
    check("busy_cycles", 32'(busy_n), 32'd60);
    if (rd) begin
      tick();
      i_shift = 1'b1;
      repeat (8) begin
        r = $urandom;
        i_data = r[3:0];
        tick();
      end
      i_shift = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    logic [31:0] got;
    int n;
    int guard;
    forever begin
      @(negedge i_clk);
      if (o_done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done with empty queue, required none");
        end else begin
          e = exp_q.pop_front();
          check("done_nibble", {28'h0, o_data}, {28'h0, e.pt[31:28]});
          if (e.rd) begin
            got = '0;
            n = 0;
            guard = 0;
            while (n < 8 && guard < 40) begin
              @(negedge i_clk);
              guard++;
              if (i_shift && !o_busy && !o_done) begin
                got = {got[27:0], o_data};
                n++;
              end
            end
            check("readout", got, e.pt);
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : stim
    logic [63:0] key;
    logic [31:0] pt;
    logic [31:0] ct;
    i_rst_n = 1'b0;
    i_shift = 1'b0;
    i_start = 1'b0;
    i_data  = 4'h0;
    #12;
    check("rst_data", {28'h0, o_data}, 32'h0);
    check("rst_busy", {31'h0, o_busy}, 32'h0);
    check("rst_done", {31'h0, o_done}, 32'h0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Reference vector
    load(KNOWN);
    check("load_top", {28'h0, o_data}, 32'h1);
    run_op(KNOWN_PT, 1'b1, 1'b0);

    // Shift has priority over start
    load(KNOWN);
    i_shift = 1'b1;
    i_start = 1'b1;
    i_data  = 4'ha;
    tick();
    i_shift = 1'b0;
    i_start = 1'b0;
    check("prio_data", {28'h0, o_data}, 32'h9);
    check("prio_busy0", {31'h0, o_busy}, 32'h0);
    tick();
    check("prio_busy1", {31'h0, o_busy}, 32'h0);

    // Inputs toggling while busy
    load(KNOWN);
    run_op(KNOWN_PT, 1'b1, 1'b1);

    // Asynchronous reset in the middle of decryption
    load(KNOWN);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (38) tick();
    check("mid_busy", {31'h0, o_busy}, 32'h1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_busy", {31'h0, o_busy}, 32'h0);
    check("arst_data", {28'h0, o_data}, 32'h0);
    check("arst_done", {31'h0, o_done}, 32'h0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    tick();
    check("post_rst_busy", {31'h0, o_busy}, 32'h0);
    load(KNOWN);
    run_op(KNOWN_PT, 1'b1, 1'b0);

    // Back-to-back: second start reuses sr = {plaintext, 64'b0}
    load(KNOWN);
    run_op(KNOWN_PT, 1'b0, 1'b0);
    tick();
    run_op(decrypt({KNOWN_PT, 32'h0}, 32'h0), 1'b1, 1'b0);

    // Random key/plaintext pairs
    for (int i = 0; i < 100; i++) begin
      key = {$urandom, $urandom};
      pt  = $urandom;
      ct  = encrypt(key, pt);
      load({key, ct});
      run_op(pt, 1'b1, 1'b0);
    end

    repeat (5) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
